// File: rtl/maze_episode_ctrl.sv
// Maze episode sequencer: takes one agent action at a time, moves the agent on
// a configurable GRID_W x GRID_W cell map and returns next state, reward and
// done/timeout, restarting episodes and keeping step/episode counters.
module maze_episode_ctrl #(
  parameter int unsigned GRID_W    = 10,
  parameter logic [7:0]  START_LOC = 8'd0,
  parameter int unsigned MAX_STEPS = 200,
  parameter int          R_STEP    = -1,
  parameter int          R_BUMP    = -5,
  parameter int          R_GOAL    = 100,
  parameter int          R_PIT     = -100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_addr,
  input  logic [3:0]  cfg_data,
  input  logic        start,
  input  logic        stop,
  input  logic        act_valid,
  output logic        act_ready,
  input  logic [1:0]  act,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  state,
  output logic [7:0]  next_state,
  output logic [7:0]  reward,
  output logic        done,
  output logic        timeout,
  output logic [15:0] step_cnt,
  output logic [15:0] episode_cnt,
  output logic        busy
);

  localparam int unsigned NCELLS    = GRID_W * GRID_W;
  localparam int unsigned AW        = $clog2(NCELLS);
  localparam logic [7:0]  GW8       = 8'(GRID_W);
  localparam logic [7:0]  LAST      = 8'(GRID_W - 1);
  localparam logic [7:0]  NCELLS8   = 8'(NCELLS);
  localparam logic [7:0]  START_ROW = 8'(32'(START_LOC) / GRID_W);
  localparam logic [7:0]  START_COL = 8'(32'(START_LOC) % GRID_W);
  localparam logic [15:0] MAX16     = 16'(MAX_STEPS);
  localparam logic [7:0]  RW_STEP   = 8'(R_STEP);
  localparam logic [7:0]  RW_BUMP   = 8'(R_BUMP);
  localparam logic [7:0]  RW_GOAL   = 8'(R_GOAL);
  localparam logic [7:0]  RW_PIT    = 8'(R_PIT);
  localparam logic [3:0]  CELL_WALL = 4'd1;
  localparam logic [3:0]  CELL_GOAL = 4'd2;
  localparam logic [3:0]  CELL_PIT  = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ACT, S_LOOKUP, S_RESP, S_EPI_END
  } fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [7:0]  state_q, state_d, row_q, row_d, col_q, col_d;
  logic [7:0]  next_state_q, next_state_d, nrow_q, nrow_d, ncol_q, ncol_d;
  logic [7:0]  reward_q, reward_d;
  logic        done_q, done_d, timeout_q, timeout_d;
  logic [15:0] step_cnt_q, step_cnt_d, episode_cnt_q, episode_cnt_d;
  logic        act_ready_q, act_ready_d, res_valid_q, res_valid_d;
  logic        busy_q, busy_d;
  logic [7:0]  tgt_q, tgt_d, trow_q, trow_d, tcol_q, tcol_d;
  logic        blocked_q, blocked_d;
  logic [3:0]  cell_q, cell_d;

  logic [3:0]  map_q [NCELLS];

  logic        map_we_c, accept_c, res_hs_c, blocked_c, terminal_c;
  logic [7:0]  tgt_c, trow_c, tcol_c;
  logic [15:0] step_inc_c;

  assign map_we_c = (fsm_q == S_IDLE) && cfg_we && (cfg_addr < NCELLS8);
  assign accept_c = act_valid && act_ready_q;
  assign res_hs_c = res_valid_q && res_ready;

  // Cell map storage; survives reset so software loads it once.
  always_ff @(posedge clk) begin
    if (map_we_c) map_q[cfg_addr[AW-1:0]] <= cfg_data;
  end

  // Target location for the offered action, with edge detection.
  always_comb begin
    blocked_c = 1'b0;
    trow_c    = row_q;
    tcol_c    = col_q;
    tgt_c     = state_q;
    case (act)
      2'd0: if (row_q == 8'd0) blocked_c = 1'b1;
            else begin trow_c = row_q - 8'd1; tgt_c = state_q - GW8; end
      2'd1: if (col_q == LAST) blocked_c = 1'b1;
            else begin tcol_c = col_q + 8'd1; tgt_c = state_q + 8'd1; end
      2'd2: if (row_q == LAST) blocked_c = 1'b1;
            else begin trow_c = row_q + 8'd1; tgt_c = state_q + GW8; end
      default: if (col_q == 8'd0) blocked_c = 1'b1;
            else begin tcol_c = col_q - 8'd1; tgt_c = state_q - 8'd1; end
    endcase
  end

  // Next-state and registered-output computation.
  always_comb begin
    fsm_d         = fsm_q;
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    next_state_d  = next_state_q;
    nrow_d        = nrow_q;
    ncol_d        = ncol_q;
    reward_d      = reward_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    step_cnt_d    = step_cnt_q;
    episode_cnt_d = episode_cnt_q;
    res_valid_d   = 1'b0;
    tgt_d         = tgt_q;
    trow_d        = trow_q;
    tcol_d        = tcol_q;
    blocked_d     = blocked_q;
    cell_d        = cell_q;
    terminal_c    = 1'b0;
    step_inc_c    = step_cnt_q + 16'd1;

    case (fsm_q)
      S_IDLE: begin
        if (start) fsm_d = S_WAIT_ACT;
      end
      S_WAIT_ACT: begin
        if (accept_c) begin
          tgt_d     = tgt_c;
          trow_d    = trow_c;
          tcol_d    = tcol_c;
          blocked_d = blocked_c;
          if (!blocked_c) cell_d = map_q[tgt_c[AW-1:0]];
          fsm_d     = S_LOOKUP;
        end else if (stop) begin
          state_d    = START_LOC;
          row_d      = START_ROW;
          col_d      = START_COL;
          step_cnt_d = 16'd0;
          fsm_d      = S_IDLE;
        end
      end
      S_LOOKUP: begin
        step_cnt_d = step_inc_c;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        if (blocked_q || cell_q == CELL_WALL) begin
          next_state_d = state_q;
          nrow_d       = row_q;
          ncol_d       = col_q;
          reward_d     = RW_BUMP;
        end else begin
          next_state_d = tgt_q;
          nrow_d       = trow_q;
          ncol_d       = tcol_q;
          if (cell_q == CELL_GOAL) begin
            reward_d   = RW_GOAL;
            terminal_c = 1'b1;
          end else if (cell_q == CELL_PIT) begin
            reward_d   = RW_PIT;
            terminal_c = 1'b1;
          end else begin
            reward_d   = RW_STEP;
          end
        end
        if (terminal_c) begin
          done_d = 1'b1;
        end else if (step_inc_c == MAX16) begin
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
        fsm_d = S_RESP;
      end
      S_RESP: begin
        res_valid_d = 1'b1;
        if (res_hs_c) begin
          res_valid_d = 1'b0;
          state_d     = next_state_q;
          row_d       = nrow_q;
          col_d       = ncol_q;
          fsm_d       = done_q ? S_EPI_END : S_WAIT_ACT;
        end
      end
      S_EPI_END: begin
        state_d       = START_LOC;
        row_d         = START_ROW;
        col_d         = START_COL;
        step_cnt_d    = 16'd0;
        episode_cnt_d = episode_cnt_q + 16'd1;
        fsm_d         = stop ? S_IDLE : S_WAIT_ACT;
      end
      default: fsm_d = S_IDLE;
    endcase

    act_ready_d = (fsm_d == S_WAIT_ACT);
    busy_d      = (fsm_d != S_IDLE);
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q         <= S_IDLE;
      state_q       <= START_LOC;
      row_q         <= START_ROW;
      col_q         <= START_COL;
      next_state_q  <= 8'd0;
      nrow_q        <= 8'd0;
      ncol_q        <= 8'd0;
      reward_q      <= 8'd0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      step_cnt_q    <= 16'd0;
      episode_cnt_q <= 16'd0;
      act_ready_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      tgt_q         <= 8'd0;
      trow_q        <= 8'd0;
      tcol_q        <= 8'd0;
      blocked_q     <= 1'b0;
      cell_q        <= 4'd0;
    end else begin
      fsm_q         <= fsm_d;
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      next_state_q  <= next_state_d;
      nrow_q        <= nrow_d;
      ncol_q        <= ncol_d;
      reward_q      <= reward_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      step_cnt_q    <= step_cnt_d;
      episode_cnt_q <= episode_cnt_d;
      act_ready_q   <= act_ready_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
      tgt_q         <= tgt_d;
      trow_q        <= trow_d;
      tcol_q        <= tcol_d;
      blocked_q     <= blocked_d;
      cell_q        <= cell_d;
    end
  end

  assign act_ready   = act_ready_q;
  assign res_valid   = res_valid_q;
  assign state       = state_q;
  assign next_state  = next_state_q;
  assign reward      = reward_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign step_cnt    = step_cnt_q;
  assign episode_cnt = episode_cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_maze_episode_ctrl.sv
// Bench for maze_episode_ctrl: table vectors plus a reference model feeding a
// scoreboard queue, with hand-written sequences for stalls, stop and reset.
module tb_maze_episode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_addr = 8'd0;
  logic [3:0]  cfg_data = 4'd0;
  logic        start = 1'b0, stop = 1'b0;
  logic        act_valid = 1'b0, res_ready = 1'b0;
  logic [1:0]  act = 2'd0;
  logic        act_ready, res_valid, done, timeout, busy;
  logic [7:0]  state, next_state, reward;
  logic [15:0] step_cnt, episode_cnt;

  maze_episode_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .stop(stop), .act_valid(act_valid), .act_ready(act_ready),
    .act(act), .res_valid(res_valid), .res_ready(res_ready), .state(state),
    .next_state(next_state), .reward(reward), .done(done), .timeout(timeout),
    .step_cnt(step_cnt), .episode_cnt(episode_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] ns; logic [7:0] rw; logic dn; logic to; } exp_t;
  typedef struct { logic [1:0] a; exp_t e; } vec_t;

  exp_t sbq[$];
  vec_t tbl[10];
  int   tests = 0, failed = 0;

  // Reference model of the environment
  int bmap[100];
  int brow = 0, bcol = 0, bsteps = 0, bepi = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic exp_t predict(input logic [1:0] a);
    exp_t e;
    int r, c, ty;
    bit blk, term;
    r = brow; c = bcol; blk = 0; term = 0;
    case (a)
      2'd0: if (r == 0) blk = 1; else r = r - 1;
      2'd1: if (c == 9) blk = 1; else c = c + 1;
      2'd2: if (r == 9) blk = 1; else r = r + 1;
      default: if (c == 0) blk = 1; else c = c - 1;
    endcase
    ty = blk ? 1 : bmap[r*10+c];
    e.dn = 0; e.to = 0;
    if (ty == 1) begin e.ns = 8'(brow*10+bcol); e.rw = 8'hFB; end
    else begin
      e.ns = 8'(r*10+c);
      if (ty == 2) begin e.rw = 8'd100; term = 1; end
      else if (ty == 3) begin e.rw = 8'h9C; term = 1; end
      else e.rw = 8'hFF;
    end
    if (term) e.dn = 1;
    else if (bsteps + 1 == 200) begin e.dn = 1; e.to = 1; end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = 8'(addr); cfg_data = 4'(data);
    tick();
    cfg_we = 1'b0;
    if (addr < 100) bmap[addr] = data;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic stop_to_idle();
    int e0;
    e0 = bepi;
    stop = 1'b1; tick(); stop = 1'b0;
    brow = 0; bcol = 0; bsteps = 0;
    chk("stop busy", busy, 0);
    chk("stop state", state, 0);
    chk("stop step_cnt", step_cnt, 0);
    chk("stop episode_cnt", episode_cnt, 32'(e0));
  endtask

  // Offer one action, push its expectation and check the response latency.
  task automatic accept_act(input logic [1:0] a, input exp_t e);
    int n;
    n = 0;
    while (!act_ready && n < 20) begin tick(); n++; end
    chk("act_ready wait", act_ready, 1);
    act = a; act_valid = 1'b1;
    sbq.push_back(e);
    tick();
    act_valid = 1'b0;
    chk("lookup act_ready", act_ready, 0);
    chk("lookup res_valid", res_valid, 0);
    tick();
    chk("resp0 res_valid", res_valid, 0);
    tick();
    chk("latency res_valid", res_valid, 1);
  endtask

  // Consume one result, optionally stalling res_ready for hold cycles.
  task automatic collect(input int hold);
    int n;
    exp_t e;
    n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
    chk("res_valid wait", res_valid, 1);
    if (sbq.size() == 0) begin
      tests++; failed++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sbq.pop_front();
    chk("next_state", next_state, 32'(e.ns));
    chk("reward", reward, 32'(e.rw));
    chk("done", done, 32'(e.dn));
    chk("timeout", timeout, 32'(e.to));
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin cfg_we = 1'b1; cfg_addr = 8'd1; cfg_data = 4'd0; end
      tick();
      cfg_we = 1'b0;
      chk("hold res_valid", res_valid, 1);
      chk("hold next_state", next_state, 32'(e.ns));
      chk("hold reward", reward, 32'(e.rw));
      chk("hold act_ready", act_ready, 0);
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("hs res_valid", res_valid, 0);
    chk("hs state", state, 32'(e.ns));
    bsteps++; brow = int'(e.ns) / 10; bcol = int'(e.ns) % 10;
    if (e.dn) begin
      tick();
      bsteps = 0; brow = 0; bcol = 0; bepi++;
    end
    chk("post state", state, 32'(brow*10+bcol));
    chk("post step_cnt", step_cnt, 32'(bsteps));
    chk("post episode_cnt", episode_cnt, 32'(bepi));
  endtask

  task automatic model_step(input logic [1:0] a);
    accept_act(a, predict(a));
    collect(0);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) tbl[i] = '{a: 2'd1, e: '{ns: 8'(i+1), rw: 8'hFF, dn: 1'b0, to: 1'b0}};
    tbl[9] = '{a: 2'd1, e: '{ns: 8'd9, rw: 8'hFB, dn: 1'b0, to: 1'b0}};
    for (int i = 0; i < 100; i++) bmap[i] = 0;

    // Reset values
    #12;
    chk("rst state", state, 0);
    chk("rst act_ready", act_ready, 0);
    chk("rst res_valid", res_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst step_cnt", step_cnt, 0);
    chk("rst episode_cnt", episode_cnt, 0);
    chk("rst reward", reward, 0);
    chk("rst done", done, 0);
    @(posedge clk); #1 rst = 1'b0;

    // All-free map (cell 5 uses a reserved code that behaves as free)
    for (int i = 0; i < 100; i++) cfg_write(i, (i == 5) ? 7 : 0);
    bmap[5] = 0;
    cfg_write(150, 1);
    pulse_start();
    chk("start busy", busy, 1);
    chk("start act_ready", act_ready, 1);

    // Walk right along row 0, bump at the east edge
    for (int i = 0; i < 10; i++) begin
      accept_act(tbl[i].a, tbl[i].e);
      collect(0);
    end
    chk("edge step_cnt", step_cnt, 10);

    // Goal in the far corner
    stop_to_idle();
    cfg_write(99, 2);
    pulse_start();
    for (int i = 0; i < 9; i++) model_step(2'd2);
    for (int i = 0; i < 9; i++) model_step(2'd1);
    chk("goal episode_cnt", episode_cnt, 1);

    // Wall then pit next to the start cell
    stop_to_idle();
    cfg_write(1, 1);
    cfg_write(10, 3);
    pulse_start();
    model_step(2'd1);
    chk("wall state", state, 0);
    model_step(2'd2);
    chk("pit episode_cnt", episode_cnt, 2);

    // Timeout after MAX_STEPS bumps in the corner
    for (int i = 0; i < 200; i++) model_step((i % 2 == 0) ? 2'd0 : 2'd3);
    chk("timeout episode_cnt", episode_cnt, 3);

    // Stalled result with a map write attempt during the run
    accept_act(2'd1, predict(2'd1));
    collect(5);
    model_step(2'd1);

    // Asynchronous reset while a result is presented
    accept_act(2'd2, predict(2'd2));
    #2 rst = 1'b1;
    #1;
    chk("arst res_valid", res_valid, 0);
    chk("arst busy", busy, 0);
    chk("arst act_ready", act_ready, 0);
    chk("arst state", state, 0);
    chk("arst next_state", next_state, 0);
    chk("arst reward", reward, 0);
    chk("arst done", done, 0);
    chk("arst step_cnt", step_cnt, 0);
    chk("arst episode_cnt", episode_cnt, 0);
    sbq.delete();
    brow = 0; bcol = 0; bsteps = 0; bepi = 0;
    @(posedge clk); #1 rst = 1'b0;
    tick();
    pulse_start();
    model_step(2'd2);
    chk("retained pit episode_cnt", episode_cnt, 1);
    chk("scoreboard drained", 32'(sbq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/maze_episode_ctrl.md
# maze_episode_ctrl

Episode sequencer for the 10x10 maze environment of the RL SoC. It accepts one action at a time from the Q-learning agent and moves the agent location on a configurable cell map. It returns the next state, reward and done/timeout flags. It restarts episodes automatically and maintains the step and episode counters that the display and debug logic read.

## Interface

Parameters:
- GRID_W, 10, cells per row/column; grid holds GRID_W*GRID_W cells, indexed row*GRID_W+col.
- START_LOC, 8'd0, agent location at reset and at every episode start.
- MAX_STEPS, 200, steps per episode before forced timeout.
- R_STEP, -1, reward for a legal move onto a free cell.
- R_BUMP, -5, reward for a move blocked by an edge or wall.
- R_GOAL, 100, reward for entering a goal cell.
- R_PIT, -100, reward for entering a pit cell.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  map write strobe; honoured only in IDLE.
- cfg_addr  in  8  cell index 0..GRID_W*GRID_W-1; out-of-range writes are ignored.
- cfg_data  in  4  cell type: 0 free, 1 wall, 2 goal, 3 pit; 4..15 behave as free.
- start  in  1  one-cycle pulse; leaves IDLE.
- stop  in  1  level; returns to IDLE at the next episode boundary.
- act_valid  in  1  action offered by agent.
- act_ready  out  1  controller accepts an action.
- act  in  2  0 up (row-1), 1 right (col+1), 2 down (row+1), 3 left (col-1).
- res_valid  out  1  result presented.
- res_ready  in  1  agent consumes result.
- state  out  8  current agent location.
- next_state  out  8  location after the action; valid with res_valid.
- reward  out  8  signed two's-complement reward; valid with res_valid.
- done  out  1  episode ended on this result (goal, pit or timeout).
- timeout  out  1  episode ended by MAX_STEPS.
- step_cnt  out  16  steps taken in the current episode.
- episode_cnt  out  16  completed episodes, wraps at 65535->0.
- busy  out  1  high in every state except IDLE.

## Operation

- The map is a GRID_W*GRID_W x 4 register array with synchronous read. It is not cleared by rst; software loads it in IDLE.
- Location is tracked internally as a row/col pair plus the linear index; no divider is used.

FSM states:
- IDLE. act_ready=0. cfg writes accepted. start moves to WAIT_ACT.
- WAIT_ACT. act_ready=1. On act_valid&&act_ready, latch act and go to LOOKUP.
  - Compute the target row/col.
  - An edge violation (row or col outside 0..GRID_W-1) marks the action as blocked; no map read is needed.
  - Otherwise read map[target].
- LOOKUP. One cycle; the map data returns.
  - Wall or edge: next_state=state, reward=R_BUMP.
  - Free: next_state=target, reward=R_STEP.
  - Goal: next_state=target, reward=R_GOAL, done=1.
  - Pit: next_state=target, reward=R_PIT, done=1.
  - step_cnt increments by 1.
  - If the incremented step_cnt equals MAX_STEPS and the move was not goal/pit: done=1, timeout=1, reward unchanged.
  - Go to RESP.
- RESP. res_valid=1, with next_state/reward/done/timeout held stable until res_ready.
  - On handshake, state<=next_state.
  - If done=0, go to WAIT_ACT. If done=1, go to EPI_END.
- EPI_END. One cycle. state<=START_LOC, step_cnt<=0, episode_cnt+=1.
  - If stop=1, go to IDLE; otherwise go to WAIT_ACT.
- stop is sampled only in EPI_END and in WAIT_ACT. In WAIT_ACT, stop=1 with no pending act_valid discards the partial episode: state<=START_LOC, step_cnt<=0, go to IDLE, episode_cnt unchanged.
- start outside IDLE is ignored. cfg_we outside IDLE is ignored.

## Timing

- Reset values:
  - state=START_LOC.
  - All of act_ready, res_valid, next_state, reward, done, timeout, step_cnt, episode_cnt, busy are 0.
  - FSM is in IDLE.
- Mid-operation reset aborts immediately to these values. Map contents are retained.
- Latency: action accepted at edge N, res_valid high after edge N+2, state updated at the edge of the res handshake.
- Throughput: one action per 4 cycles with res_ready held high. Add one extra cycle per episode end (EPI_END).
- act_ready is low in LOOKUP, RESP and EPI_END; only one action is ever in flight.
- res_valid, once asserted, never drops before res_ready. Outputs are registered.
- Reward arithmetic is 8-bit signed; parameter values must fit in -128..127.

## Test plan

- Reset, load an all-free map, then start.
  - act=1 (right) x9 -> state goes 1..9, each reward=-1 (0xFF).
  - 10th act=1 -> next_state=9, reward=-5 (0xFB), step_cnt=10.
- Set map[99]=2. Apply 9 down then 9 right from state 0 -> 18th result: next_state=99, reward=100, done=1.
  - Next cycles: state=0, step_cnt=0, episode_cnt=1.
- Set map[1]=1 (wall). act=1 from state 0 -> next_state=0, reward=-5. Set map[10]=3 (pit). act=2 -> next_state=10, reward=-100, done=1.
- MAX_STEPS=200, all-free map, alternate up-left at state 0 -> result 200 has done=1, timeout=1, reward=-5; episode_cnt increments.
- Hold res_ready=0 for 5 cycles -> res_valid stays high, outputs stable, act_ready=0. cfg_we during the run -> map unchanged.
- Assert rst while in RESP -> all outputs return to reset values asynchronously. Reissue start -> the previously loaded map is still in effect.
